awb_gray_world: RTL and testbench
=================================

Name: awb_gray_world

Overview:
- Gray-world auto white balance stage. Sits directly downstream of the Bayer-to-RGB demosaic and consumes its V_Sync / valid / R,G,B stream.
- Accumulates per-channel sums over each frame. At each frame boundary it computes R and B gains against G with a sequential restoring divider.
- Applies the current gains to the pixel stream through a 2-cycle multiply/round/saturate pipeline.

Parameters:
DATA_WIDTH, 8, pixel component width
SUM_W, 32, per-channel frame accumulator width (covers 1920x1080x255)
GAIN_FRAC, 8, fractional bits of gains (unsigned Q4.8; 256 = 1.0)
GAIN_W, 12, gain width
GAIN_MAX, 1023, upper gain clamp (~3.996)
GAIN_MIN, 64, lower gain clamp (0.25)

Ports:
I_Clk  in  1  clock
I_Rst  in  1  synchronous active-high reset
I_Awb_En  in  1  1 = apply computed gains; 0 = unity gains on datapath (statistics still run)
I_V_Sync  in  1  frame sync; rising edge = frame boundary
I_RGB_Vaild  in  1  pixel valid
I_RGB_Data_r / _g / _b  in  DATA_WIDTH each  input components
O_V_Sync  out  1  I_V_Sync delayed 2 cycles
O_RGB_Vaild  out  1  I_RGB_Vaild delayed 2 cycles
O_RGB_Data_r / _g / _b  out  DATA_WIDTH each  balanced components; 0 when O_RGB_Vaild=0
O_RGB_Concat  out  3*DATA_WIDTH  {r,g,b}
O_Gain_R, O_Gain_B  out  GAIN_W each  gains currently in effect on the datapath
O_Gain_Busy  out  1  divider active
O_Gain_Restart  out  1  1-cycle pulse when an in-flight computation is abandoned

Behaviour:
Reset (synchronous, I_Rst=1 at clock edge):
- Accumulators cleared; FSM to IDLE.
- Gain registers set to 256.
- All outputs and pipeline registers set to 0.
- A reset mid-division aborts the division with no commit.

Frame boundary:
- Pose_V_Sync = I_V_Sync & ~r1_V_Sync.
- On Pose_V_Sync: snapshot Sum_R/G/B into divider operand registers and clear the accumulators in the same cycle.
- A pixel valid in that same cycle is counted into the new frame.

Accumulation:
- Each cycle with I_RGB_Vaild=1: Sum_x += I_RGB_Data_x.
- Accumulators wrap modulo 2^SUM_W; there is no overflow detection.

FSM: IDLE -> DIV_R -> DIV_B -> COMMIT -> IDLE.
- IDLE -> DIV_R on Pose_V_Sync.
- DIV_R: restoring divide of (Snap_G << GAIN_FRAC) by Snap_R. One quotient bit per cycle, SUM_W+GAIN_FRAC = 40 cycles. Full-width quotient.
- DIV_B: same divide against Snap_B, 40 cycles.
- COMMIT (1 cycle): clamp each quotient to [GAIN_MIN, GAIN_MAX] and load O_Gain_R/O_Gain_B. The new gains take effect from the next cycle.
- Divisor == 0: that gain = 256, with no clamp applied.
- O_Gain_Busy = 1 in DIV_R, DIV_B and COMMIT. Total 81 cycles.
- Pose_V_Sync while busy: re-snapshot, clear accumulators, restart at DIV_R, pulse O_Gain_Restart. Gains are unchanged.

Datapath (latency 2, applies to every pixel regardless of FSM state):
- Effective gain = I_Awb_En ? O_Gain_x : 256.
- Stage 1: P_r = r*gain_r, P_b = b*gain_b (DATA_WIDTH+GAIN_W bits). G registered unchanged.
- Stage 2: out = (P + 2^(GAIN_FRAC-1)) >> GAIN_FRAC, saturated to 2^DATA_WIDTH-1.
- If a commit lands mid-frame, pixels entering stage 1 after the commit cycle use the new gains. There is no mid-pixel tearing.
- O_V_Sync and O_RGB_Vaild go through the same 2-stage delay.
- Data outputs are forced to 0 when the delayed valid is 0.

Test Plan:
- Reset, then a frame of 8 valid pixels (64,128,32), then V_Sync rising -> O_Gain_Busy high for exactly 81 cycles. Then O_Gain_R = 512 and O_Gain_B = 1023 (clamped from 1024).
- Following frame, pixel (64,128,32) with I_Awb_En=1 -> output (128,128,128) 2 cycles later. With I_Awb_En=0 -> (64,128,32).
- Saturation: gain_r = 512, input r = 200 -> out r = 255. Input r = 1 with gain 384 -> out r = 2 (384+128=512, >>8 = 2; rounding check).
- Degenerate sums: frame of (0,50,10) -> O_Gain_R = 256 (zero divisor), O_Gain_B = 1023. Frame of (10,0,10) -> both gains = 64 (GAIN_MIN clamp).
- Second V_Sync rising 20 cycles into the division -> O_Gain_Restart pulses once, busy lasts 81 cycles from the second edge, and the committed gains reflect the second snapshot only.
- Assert I_Rst during DIV_B -> next cycle busy = 0, gains = 256, all outputs 0. The next full frame recomputes correctly.

Source files
------------

// File: rtl/awb_gray_world.sv
// Gray-world auto white balance: per-frame channel sums feed a sequential divider that produces R/B gains vs G.
// Pixel latency 2 cycles; the stream never stalls (no backpressure); gain computation runs 81 cycles after each frame edge.
module awb_gray_world #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_W      = 32,
  parameter int GAIN_FRAC  = 8,
  parameter int GAIN_W     = 12,
  parameter int GAIN_MAX   = 1023,
  parameter int GAIN_MIN   = 64
) (
  input  logic                    I_Clk,
  input  logic                    I_Rst,
  input  logic                    I_Awb_En,
  input  logic                    I_V_Sync,
  input  logic                    I_RGB_Vaild,
  input  logic [DATA_WIDTH-1:0]   I_RGB_Data_r,
  input  logic [DATA_WIDTH-1:0]   I_RGB_Data_g,
  input  logic [DATA_WIDTH-1:0]   I_RGB_Data_b,
  output logic                    O_V_Sync,
  output logic                    O_RGB_Vaild,
  output logic [DATA_WIDTH-1:0]   O_RGB_Data_r,
  output logic [DATA_WIDTH-1:0]   O_RGB_Data_g,
  output logic [DATA_WIDTH-1:0]   O_RGB_Data_b,
  output logic [3*DATA_WIDTH-1:0] O_RGB_Concat,
  output logic [GAIN_W-1:0]       O_Gain_R,
  output logic [GAIN_W-1:0]       O_Gain_B,
  output logic                    O_Gain_Busy,
  output logic                    O_Gain_Restart
);

  localparam int QW = SUM_W + GAIN_FRAC;
  localparam int PW = DATA_WIDTH + GAIN_W;
  localparam int CW = $clog2(QW);
  localparam logic [GAIN_W-1:0]     UNITY   = GAIN_W'(1 << GAIN_FRAC);
  localparam logic [QW-1:0]         Q_MAX   = QW'(GAIN_MAX);
  localparam logic [QW-1:0]         Q_MIN   = QW'(GAIN_MIN);
  localparam logic [PW:0]           ROUND   = (PW+1)'(1 << (GAIN_FRAC-1));
  localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, COMMIT} state_t;

  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [QW-1:0] q, input logic zero_div);
    if (zero_div)  return UNITY;
    if (q > Q_MAX) return Q_MAX[GAIN_W-1:0];
    if (q < Q_MIN) return Q_MIN[GAIN_W-1:0];
    return q[GAIN_W-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic [PW-1:0] p);
    logic [PW:0] shr;
    shr = ({1'b0, p} + ROUND) >> GAIN_FRAC;
    if (|shr[PW:DATA_WIDTH]) return PIX_MAX;
    return shr[DATA_WIDTH-1:0];
  endfunction

  // ---------------- frame statistics ----------------
  logic             vs_q;
  logic             pose;
  logic [SUM_W-1:0] sum_r_q, sum_g_q, sum_b_q;
  logic [SUM_W-1:0] sum_r_d, sum_g_d, sum_b_d;

  assign pose = I_V_Sync & ~vs_q;

  // The pixel coincident with the frame edge opens the new frame.
  always_comb begin
    sum_r_d = pose ? '0 : sum_r_q;
    sum_g_d = pose ? '0 : sum_g_q;
    sum_b_d = pose ? '0 : sum_b_q;
    if (I_RGB_Vaild) begin
      sum_r_d = sum_r_d + SUM_W'(I_RGB_Data_r);
      sum_g_d = sum_g_d + SUM_W'(I_RGB_Data_g);
      sum_b_d = sum_b_d + SUM_W'(I_RGB_Data_b);
    end
  end

  always_ff @(posedge I_Clk) begin
    if (I_Rst) begin
      vs_q    <= 1'b0;
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
    end else begin
      vs_q    <= I_V_Sync;
      sum_r_q <= sum_r_d;
      sum_g_q <= sum_g_d;
      sum_b_q <= sum_b_d;
    end
  end

  // ---------------- gain computation ----------------
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [QW-1:0]    dvd_q;
  logic [QW-1:0]    quo_q;
  logic [QW-1:0]    qr_q;
  logic [SUM_W-1:0] rem_q;
  logic [SUM_W-1:0] snap_r_q, snap_g_q, snap_b_q;
  logic [GAIN_W-1:0] gain_r_q, gain_b_q;
  logic             busy_q, restart_q;

  logic [SUM_W-1:0] divisor;
  logic [SUM_W:0]   rem_sh;
  logic             q_bit;
  logic [QW-1:0]    quo_nx;

  always_comb begin
    divisor = (state_q == DIV_B) ? snap_b_q : snap_r_q;
    rem_sh  = {rem_q, dvd_q[QW-1]};
    q_bit   = (rem_sh >= {1'b0, divisor});
    quo_nx  = {quo_q[QW-2:0], q_bit};
  end

  always_ff @(posedge I_Clk) begin
    if (I_Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      qr_q      <= '0;
      rem_q     <= '0;
      snap_r_q  <= '0;
      snap_g_q  <= '0;
      snap_b_q  <= '0;
      gain_r_q  <= UNITY;
      gain_b_q  <= UNITY;
      busy_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      restart_q <= 1'b0;
      if (pose) begin
        // A new frame edge always wins, abandoning any computation in flight.
        restart_q <= (state_q != IDLE);
        snap_r_q  <= sum_r_q;
        snap_g_q  <= sum_g_q;
        snap_b_q  <= sum_b_q;
        dvd_q     <= {sum_g_q, GAIN_FRAC'(0)};
        rem_q     <= '0;
        quo_q     <= '0;
        cnt_q     <= '0;
        busy_q    <= 1'b1;
        state_q   <= DIV_R;
      end else begin
        case (state_q)
          DIV_R, DIV_B: begin
            dvd_q <= {dvd_q[QW-2:0], 1'b0};
            rem_q <= q_bit ? SUM_W'(rem_sh - {1'b0, divisor}) : rem_sh[SUM_W-1:0];
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(QW-1)) begin
              cnt_q <= '0;
              if (state_q == DIV_R) begin
                qr_q    <= quo_nx;
                dvd_q   <= {snap_g_q, GAIN_FRAC'(0)};
                rem_q   <= '0;
                quo_q   <= '0;
                state_q <= DIV_B;
              end else begin
                state_q <= COMMIT;
              end
            end
          end
          COMMIT: begin
            gain_r_q <= clamp_gain(qr_q, snap_r_q == '0);
            gain_b_q <= clamp_gain(quo_q, snap_b_q == '0);
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- pixel datapath ----------------
  logic [GAIN_W-1:0]     gain_r_eff, gain_b_eff;
  logic [PW-1:0]         p_r_q, p_b_q;
  logic [DATA_WIDTH-1:0] g1_q;
  logic                  vld1_q, vs1_q;
  logic [DATA_WIDTH-1:0] out_r_q, out_g_q, out_b_q;
  logic                  vld2_q, vs2_q;

  assign gain_r_eff = I_Awb_En ? gain_r_q : UNITY;
  assign gain_b_eff = I_Awb_En ? gain_b_q : UNITY;

  always_ff @(posedge I_Clk) begin
    if (I_Rst) begin
      p_r_q   <= '0;
      p_b_q   <= '0;
      g1_q    <= '0;
      vld1_q  <= 1'b0;
      vs1_q   <= 1'b0;
      out_r_q <= '0;
      out_g_q <= '0;
      out_b_q <= '0;
      vld2_q  <= 1'b0;
      vs2_q   <= 1'b0;
    end else begin
      p_r_q   <= PW'(I_RGB_Data_r) * PW'(gain_r_eff);
      p_b_q   <= PW'(I_RGB_Data_b) * PW'(gain_b_eff);
      g1_q    <= I_RGB_Data_g;
      vld1_q  <= I_RGB_Vaild;
      vs1_q   <= I_V_Sync;
      out_r_q <= vld1_q ? round_sat(p_r_q) : '0;
      out_g_q <= vld1_q ? g1_q : '0;
      out_b_q <= vld1_q ? round_sat(p_b_q) : '0;
      vld2_q  <= vld1_q;
      vs2_q   <= vs1_q;
    end
  end

  assign O_V_Sync       = vs2_q;
  assign O_RGB_Vaild    = vld2_q;
  assign O_RGB_Data_r   = out_r_q;
  assign O_RGB_Data_g   = out_g_q;
  assign O_RGB_Data_b   = out_b_q;
  assign O_RGB_Concat   = {out_r_q, out_g_q, out_b_q};
  assign O_Gain_R       = gain_r_q;
  assign O_Gain_B       = gain_b_q;
  assign O_Gain_Busy    = busy_q;
  assign O_Gain_Restart = restart_q;

endmodule

// File: tb/tb_awb_gray_world.sv
// Bench for awb_gray_world: directed and random frames checked every cycle against a frame-level arithmetic model.
module tb_awb_gray_world;

  logic        I_Clk = 1'b0;
  logic        I_Rst = 1'b0, I_Awb_En = 1'b0, I_V_Sync = 1'b0, I_RGB_Vaild = 1'b0;
  logic [7:0]  I_RGB_Data_r = '0, I_RGB_Data_g = '0, I_RGB_Data_b = '0;
  logic        O_V_Sync, O_RGB_Vaild, O_Gain_Busy, O_Gain_Restart;
  logic [7:0]  O_RGB_Data_r, O_RGB_Data_g, O_RGB_Data_b;
  logic [23:0] O_RGB_Concat;
  logic [11:0] O_Gain_R, O_Gain_B;

  always #5 I_Clk = ~I_Clk;

  awb_gray_world dut (
    .I_Clk(I_Clk), .I_Rst(I_Rst), .I_Awb_En(I_Awb_En), .I_V_Sync(I_V_Sync),
    .I_RGB_Vaild(I_RGB_Vaild), .I_RGB_Data_r(I_RGB_Data_r), .I_RGB_Data_g(I_RGB_Data_g),
    .I_RGB_Data_b(I_RGB_Data_b), .O_V_Sync(O_V_Sync), .O_RGB_Vaild(O_RGB_Vaild),
    .O_RGB_Data_r(O_RGB_Data_r), .O_RGB_Data_g(O_RGB_Data_g), .O_RGB_Data_b(O_RGB_Data_b),
    .O_RGB_Concat(O_RGB_Concat), .O_Gain_R(O_Gain_R), .O_Gain_B(O_Gain_B),
    .O_Gain_Busy(O_Gain_Busy), .O_Gain_Restart(O_Gain_Restart)
  );

  typedef struct { bit vs; bit vld; int r; int g; int b; } px_t;

  int        n_cmp = 0, n_err = 0;
  bit [31:0] m_sr = 0, m_sg = 0, m_sb = 0;
  int        m_gr = 256, m_gb = 256, p_gr = 256, p_gb = 256;
  int        m_cnt = 0;
  bit        m_pvs = 0;
  px_t       prev = '{0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int apply_gain(int x, int g);
    int y;
    y = (x * g + 128) / 256;
    return (y > 255) ? 255 : y;
  endfunction

  // Gain = G/X in Q.8, zero divisor means unity, otherwise clamped to [64,1023].
  function automatic int calc_gain(bit [31:0] num, bit [31:0] den);
    longint unsigned n, d, q;
    if (den == 0) return 256;
    n = num;
    d = den;
    q = (n * 256) / d;
    if (q > 1023) return 1023;
    if (q < 64) return 64;
    return int'(q);
  endfunction

  // One clock: drive inputs, advance, update the model, compare every output.
  task automatic step(input bit rst, input bit vs, input bit vld, input bit en,
                      input int r, input int g, input int b);
    px_t cur;
    bit  pose, exp_rs;
    I_Rst = rst; I_V_Sync = vs; I_RGB_Vaild = vld; I_Awb_En = en;
    I_RGB_Data_r = 8'(r); I_RGB_Data_g = 8'(g); I_RGB_Data_b = 8'(b);
    cur = '{0, 0, 0, 0, 0};
    if (!rst) begin
      cur.vs  = vs;
      cur.vld = vld;
      if (vld) begin
        cur.r = apply_gain(r, en ? m_gr : 256);
        cur.g = g;
        cur.b = apply_gain(b, en ? m_gb : 256);
      end
    end
    pose = !rst && vs && !m_pvs;
    @(posedge I_Clk);
    #1;
    exp_rs = 1'b0;
    if (rst) begin
      m_sr = 0; m_sg = 0; m_sb = 0;
      m_gr = 256; m_gb = 256; m_cnt = 0; m_pvs = 0;
      prev = '{0, 0, 0, 0, 0};
    end else begin
      exp_rs = pose && (m_cnt > 0);
      if (pose) begin
        p_gr = calc_gain(m_sg, m_sr);
        p_gb = calc_gain(m_sg, m_sb);
        m_cnt = 81;
        m_sr = 0; m_sg = 0; m_sb = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_gr = p_gr;
          m_gb = p_gb;
        end
      end
      if (vld) begin
        m_sr += 32'(r); m_sg += 32'(g); m_sb += 32'(b);
      end
      m_pvs = vs;
    end
    chk("o_v_sync", O_V_Sync, prev.vs);
    chk("o_valid", O_RGB_Vaild, prev.vld);
    chk("o_r", O_RGB_Data_r, prev.r);
    chk("o_g", O_RGB_Data_g, prev.g);
    chk("o_b", O_RGB_Data_b, prev.b);
    chk("o_concat", O_RGB_Concat, {8'(prev.r), 8'(prev.g), 8'(prev.b)});
    chk("gain_r", O_Gain_R, m_gr);
    chk("gain_b", O_Gain_B, m_gb);
    chk("busy", O_Gain_Busy, m_cnt > 0);
    chk("restart", O_Gain_Restart, exp_rs);
    prev = cur;
  endtask

  task automatic frame(input int n, input int r, input int g, input int b);
    repeat (n) step(0, 0, 1, 1, r, g, b);
  endtask

  task automatic pulse_wait();
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    repeat (90) step(0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    int n, w;
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);

    // Basic frame: gains 512 and 1023 (clamped from 1024)
    frame(8, 64, 128, 32);
    pulse_wait();
    chk("plan_gain_r", O_Gain_R, 512);
    chk("plan_gain_b", O_Gain_B, 1023);

    // Applied gains, bypass and saturation
    step(0, 0, 1, 1, 64, 128, 32);
    step(0, 0, 1, 0, 64, 128, 32);
    chk("plan_awb_on", O_RGB_Concat, 24'h808080);
    step(0, 0, 1, 1, 200, 10, 0);
    chk("plan_awb_off", O_RGB_Concat, 24'h408020);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("plan_saturate", O_RGB_Data_r, 255);

    // Rounding with gain 384
    pulse_wait();
    frame(4, 100, 150, 100);
    pulse_wait();
    chk("plan_gain_384", O_Gain_R, 384);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("plan_round", O_RGB_Data_r, 2);

    // Degenerate sums
    pulse_wait();
    frame(4, 0, 50, 10);
    pulse_wait();
    chk("plan_zero_div_r", O_Gain_R, 256);
    chk("plan_clamp_b", O_Gain_B, 1023);
    frame(4, 10, 0, 10);
    pulse_wait();
    chk("plan_min_r", O_Gain_R, 64);
    chk("plan_min_b", O_Gain_B, 64);

    // Restart 20 cycles into the division; only the second snapshot commits
    pulse_wait();
    frame(6, 50, 100, 50);
    step(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      if (i < 10) step(0, 0, 1, 1, 100, 100, 25);
      else step(0, 0, 0, 1, 0, 0, 0);
    end
    step(0, 1, 0, 1, 0, 0, 0);
    chk("plan_restart_pulse", O_Gain_Restart, 1);
    repeat (90) step(0, 0, 0, 1, 0, 0, 0);
    chk("plan_restart_gain_r", O_Gain_R, 256);
    chk("plan_restart_gain_b", O_Gain_B, 1023);

    // Reset during DIV_B, then a clean recompute
    frame(8, 30, 90, 60);
    step(0, 1, 0, 1, 0, 0, 0);
    repeat (50) step(0, 0, 1, 1, 7, 7, 7);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("plan_rst_busy", O_Gain_Busy, 0);
    chk("plan_rst_gain_r", O_Gain_R, 256);
    chk("plan_rst_out", O_RGB_Concat, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    frame(8, 64, 128, 32);
    pulse_wait();
    chk("plan_after_rst_r", O_Gain_R, 512);
    chk("plan_after_rst_b", O_Gain_B, 1023);

    // Random frames, with pixels flowing through divisions, commits and restarts
    for (int f = 0; f < 10; f++) begin
      n = int'($urandom_range(40, 10));
      for (int i = 0; i < n; i++)
        step(0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
             int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
      step(0, 1, 1'($urandom_range(1)), 1'b1,
           int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
      w = int'($urandom_range(120, 20));
      for (int i = 0; i < w; i++)
        step(0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
             int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
    end
    repeat (90) step(0, 0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
